decoder_nto2n_seq: RTL and testbench
====================================

Name: decoder_nto2n_seq

Overview:
- Registered, parametrised N-to-NUM_OUT one-hot decoder with a valid/ready input and two operating modes.
- DIRECT mode decodes a host-supplied index, with hold or single-cycle pulse output.
- SCAN mode walks the active output round-robin from an internal counter, for display digit / row select and chip-select strobing.
- Successor to the fixed 3-to-8 combinational decoder in the combinational library.

Parameters:
- SEL_W, 3, index width in bits; must be >= 1.
- NUM_OUT, 8, number of one-hot outputs; must satisfy 2 <= NUM_OUT <= 2**SEL_W.
- SCAN_DIV, 4, clock cycles each output stays active in SCAN mode; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  block enable.
- mode  input  1  0 = DIRECT, 1 = SCAN.
- pulse  input  1  DIRECT only: 1 = single-cycle output, 0 = hold output.
- in_valid  input  1  sel is valid.
- in_ready  output  1  block accepts sel this cycle.
- sel  input  SEL_W  index to decode.
- y  output  NUM_OUT  registered one-hot output.
- y_valid  output  1  y reflects a decoded or scanned index.
- idx  output  SEL_W  index currently driving y.

Behaviour:
- One clock (clk); reset rst_n is synchronous and active-low. All state changes occur on the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - y=0, y_valid=0, idx=0, scan divider=0, state=IDLE.
  - in_ready is 0 while rst_n=0.
  - Reset mid-pulse or mid-scan aborts immediately.
- in_ready = rst_n & en & ~mode (combinational). Accept = in_valid & in_ready.
- States:
  - IDLE: y=0, y_valid=0.
  - DIRECT_HOLD: y held.
  - DIRECT_PULSE: y active for one cycle.
  - SCAN: round-robin walk.
- en=0 from any state: next cycle y=0, y_valid=0, divider=0, state=IDLE. idx keeps its last value.
- DIRECT, latency 1:
  - Accept at edge k: y = onehot(sel), y_valid=1, idx=sel, all visible after edge k.
  - pulse=1: state DIRECT_PULSE. At edge k+1, with no new accept, y=0, y_valid=0, IDLE.
  - pulse=0: state DIRECT_HOLD. y holds until the next accept, en=0, or a mode change.
  - Back-to-back accepts: y updates every cycle. A pulse followed by an immediate accept yields no zero gap.
  - pulse is sampled at the accept edge only.
- Out-of-range (sel >= NUM_OUT): accepted normally; y=0, y_valid=1, idx=sel. Pulse/hold timing is unchanged.
- SCAN:
  - mode rising (with en=1) at edge k: idx=0, y=onehot(0), y_valid=1, divider=0, state=SCAN, all after edge k.
  - Each edge: divider increments. When divider==SCAN_DIV-1, divider clears and idx advances.
  - idx wraps NUM_OUT-1 -> 0; values >= NUM_OUT are never visited.
  - SCAN_DIV=1: idx advances every cycle.
  - in_valid is ignored (in_ready=0).
- Mode change SCAN -> DIRECT: next cycle y=0, y_valid=0, IDLE. An accept is possible the cycle mode=0 is seen, since in_ready is combinational and the accept takes priority.
- Mode change DIRECT -> SCAN: any held or pulsing output is replaced by onehot(0) next cycle.
- Invariant: y is all-zero or has exactly one bit set. y != 0 implies y_valid=1.
- Priority order: reset > en=0 > mode transition > accept > pulse expiry / scan advance.

Optional Feature:
- Macro DEC_OOR_ERR_EN.
- When defined, adds port oor_err (output, 1 bit): sticky flag, set the cycle after an out-of-range sel is accepted.
  - Cleared only by reset or by an accept with in-range sel while en=1 and mode=0.
  - Reset value 0.
- When undefined, the port and its logic are absent. Out-of-range handling of y, y_valid and idx is identical in both builds.

Test Plan:
- Reset, then DIRECT hold, defaults: en=1, mode=0, pulse=0, accept sel=5 -> after one edge y=8'b0010_0000, y_valid=1, idx=5. Holds 10 cycles with in_valid=0.
- DIRECT pulse: pulse=1, accept sel=2 for one cycle -> y=8'b0000_0100 for exactly one cycle, then y=0, y_valid=0. Accepts sel=0,1,7 on consecutive cycles -> y=01,02,80 (hex) on consecutive cycles, with no gaps.
- SCAN: SEL_W=3, NUM_OUT=6, SCAN_DIV=3, mode raised -> idx sequence 0,0,0,1,1,1,…,5,5,5,0, so index 6 never appears. in_ready=0 throughout. Dropping mode -> y=0 next cycle.
- Out-of-range: NUM_OUT=6, accept sel=7 -> y=0, y_valid=1, idx=7. With DEC_OOR_ERR_EN: oor_err=1 and stays set; a later accept of sel=3 clears it.
- Abort cases: en=0 mid-scan at idx=3 -> y=0, y_valid=0 next cycle, and re-entering SCAN restarts at idx=0. rst_n=0 during a hold -> all outputs 0 at the next edge.
- SCAN_DIV=1 with NUM_OUT=8 -> one-hot bit rotates every cycle 01→02→…→80→01. Check the one-hot/zero invariant every cycle.

Source files
------------

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-NUM_OUT one-hot decoder with DIRECT (hold/pulse) and SCAN (round-robin) modes.
// Optional build macro DEC_OOR_ERR_EN adds a sticky out-of-range error flag (oor_err).
module decoder_nto2n_seq #(
  parameter int SEL_W    = 3,
  parameter int NUM_OUT  = 8,
  parameter int SCAN_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               pulse,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] y,
  output logic               y_valid,
  output logic [SEL_W-1:0]   idx
`ifdef DEC_OOR_ERR_EN
  ,
  output logic               oor_err
`endif
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OUT - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DIRECT_HOLD  = 2'd1,
    DIRECT_PULSE = 2'd2,
    SCAN         = 2'd3
  } state_t;

  state_t             state_reg;
  logic [NUM_OUT-1:0] y_reg;
  logic               y_valid_reg;
  logic [SEL_W-1:0]   idx_reg;
  logic [DIV_W-1:0]   div_reg;

  logic [SEL_W-1:0]   scan_idx_next;
  logic [NUM_OUT-1:0] dec_sel;
  logic [NUM_OUT-1:0] dec_scan;
  logic               accept;

  assign in_ready      = rst_n & en & ~mode;
  assign accept        = in_valid & in_ready;
  assign scan_idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + SEL_W'(1);

  // Out-of-range indices simply match no output, so the decode is all-zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_dec
      assign dec_sel[gi]  = (sel == SEL_W'(gi));
      assign dec_scan[gi] = (scan_idx_next == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
      idx_reg     <= '0;
      div_reg     <= '0;
    end else if (!en) begin
      state_reg   <= IDLE;
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
      div_reg     <= '0;
    end else if (mode) begin
      if (state_reg != SCAN) begin
        state_reg   <= SCAN;
        y_reg       <= NUM_OUT'(1);
        y_valid_reg <= 1'b1;
        idx_reg     <= '0;
        div_reg     <= '0;
      end else if (div_reg == DIV_LAST) begin
        div_reg <= '0;
        idx_reg <= scan_idx_next;
        y_reg   <= dec_scan;
      end else begin
        div_reg <= div_reg + DIV_W'(1);
      end
    end else if (accept) begin
      // Accept wins over leaving SCAN and over pulse expiry: no zero gap.
      state_reg   <= pulse ? DIRECT_PULSE : DIRECT_HOLD;
      y_reg       <= dec_sel;
      y_valid_reg <= 1'b1;
      idx_reg     <= sel;
      div_reg     <= '0;
    end else if (state_reg == SCAN || state_reg == DIRECT_PULSE) begin
      state_reg   <= IDLE;
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
      div_reg     <= '0;
    end
  end

`ifdef DEC_OOR_ERR_EN
  logic oor_err_reg;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oor_err_reg <= 1'b0;
    end else if (accept) begin
      oor_err_reg <= ~|dec_sel;
    end
  end
  assign oor_err = oor_err_reg;
`endif

  assign y       = y_reg;
  assign y_valid = y_valid_reg;
  assign idx     = idx_reg;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Directed bench: three decoder configurations share stimulus, each checked against hand-computed values.
module tb_decoder_nto2n_seq;

  logic clk = 1'b0;
  logic rst_n, en, mode, pulse, in_valid;
  logic [2:0] sel;

  logic [7:0] y0, y2;
  logic [5:0] y1;
  logic [2:0] idx0, idx1, idx2;
  logic yv0, yv1, yv2, rdy0, rdy1, rdy2;
`ifdef DEC_OOR_ERR_EN
  logic oor0, oor1, oor2;
`endif

  int n_total = 0;
  int n_bad   = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  decoder_nto2n_seq #(.SEL_W(3), .NUM_OUT(8), .SCAN_DIV(4)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .pulse(pulse),
    .in_valid(in_valid), .in_ready(rdy0), .sel(sel),
    .y(y0), .y_valid(yv0), .idx(idx0)
`ifdef DEC_OOR_ERR_EN
    , .oor_err(oor0)
`endif
  );

  decoder_nto2n_seq #(.SEL_W(3), .NUM_OUT(6), .SCAN_DIV(3)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .pulse(pulse),
    .in_valid(in_valid), .in_ready(rdy1), .sel(sel),
    .y(y1), .y_valid(yv1), .idx(idx1)
`ifdef DEC_OOR_ERR_EN
    , .oor_err(oor1)
`endif
  );

  decoder_nto2n_seq #(.SEL_W(3), .NUM_OUT(8), .SCAN_DIV(1)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .pulse(pulse),
    .in_valid(in_valid), .in_ready(rdy2), .sel(sel),
    .y(y2), .y_valid(yv2), .idx(idx2)
`ifdef DEC_OOR_ERR_EN
    , .oor_err(oor2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [2:0] s, input logic p);
    sel      = s;
    pulse    = p;
    in_valid = 1'b1;
    step();
    $display("txn: accept sel=%0d pulse=%0d -> y0=%02h idx0=%0d y1=%02h idx1=%0d", s, p, y0, idx0, y1, idx1);
  endtask

  // One-hot/zero and y!=0 -> y_valid invariant, sampled away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("inv0", 32'(($countones(y0) <= 1) && (y0 == 0 || yv0)), 32'd1);
      check("inv1", 32'(($countones(y1) <= 1) && (y1 == 0 || yv1)), 32'd1);
      check("inv2", 32'(($countones(y2) <= 1) && (y2 == 0 || yv2)), 32'd1);
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; pulse = 1'b0; in_valid = 1'b0; sel = '0;
    step();
    step();
    check("rst_y", 32'(y0), 32'h0);
    check("rst_yv", 32'(yv0), 32'd0);
    check("rst_idx", 32'(idx0), 32'd0);
    check("rst_rdy", 32'(rdy0), 32'd0);
    started = 1'b1;

    rst_n = 1'b1; en = 1'b1;
    #1;
    check("rdy_direct", 32'(rdy0), 32'd1);

    // DIRECT hold
    accept(3'd5, 1'b0);
    in_valid = 1'b0;
    check("hold_y", 32'(y0), 32'h20);
    check("hold_yv", 32'(yv0), 32'd1);
    check("hold_idx", 32'(idx0), 32'd5);
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_keep", 32'({yv0, y0}), 32'h120);
    end

    // DIRECT pulse, single-cycle
    accept(3'd2, 1'b1);
    in_valid = 1'b0;
    check("pulse_y", 32'(y0), 32'h04);
    check("pulse_yv", 32'(yv0), 32'd1);
    step();
    check("pulse_end_y", 32'(y0), 32'h0);
    check("pulse_end_yv", 32'(yv0), 32'd0);

    // Back-to-back pulses: no zero gap
    accept(3'd0, 1'b1);
    check("b2b_0", 32'(y0), 32'h01);
    accept(3'd1, 1'b1);
    check("b2b_1", 32'(y0), 32'h02);
    accept(3'd7, 1'b1);
    check("b2b_7", 32'(y0), 32'h80);
    in_valid = 1'b0;
    step();
    check("b2b_end", 32'({yv0, y0}), 32'h000);

    // Out-of-range on the NUM_OUT=6 instance
    accept(3'd7, 1'b0);
    in_valid = 1'b0;
    check("oor_y", 32'(y1), 32'h0);
    check("oor_yv", 32'(yv1), 32'd1);
    check("oor_idx", 32'(idx1), 32'd7);
    check("oor_ref_y0", 32'(y0), 32'h80);
`ifdef DEC_OOR_ERR_EN
    check("oor_err1_set", 32'(oor1), 32'd1);
    check("oor_err0_clr", 32'(oor0), 32'd0);
`endif
    repeat (3) step();
    check("oor_hold_yv", 32'({yv1, y1}), 32'h40);
`ifdef DEC_OOR_ERR_EN
    check("oor_err1_sticky", 32'(oor1), 32'd1);
`endif
    accept(3'd3, 1'b0);
    in_valid = 1'b0;
    check("inr_y1", 32'(y1), 32'h08);
`ifdef DEC_OOR_ERR_EN
    check("oor_err1_cleared", 32'(oor1), 32'd0);
`endif

    // SCAN walk on all three instances; in_valid asserted to show it is ignored
    mode = 1'b1; in_valid = 1'b1; sel = 3'd7;
    #1;
    check("scan_rdy1", 32'(rdy1), 32'd0);
    for (int i = 0; i <= 18; i++) begin
      step();
      check("scan_idx1", 32'(idx1), 32'((i / 3) % 6));
      check("scan_y1", 32'(y1), 32'(6'd1 << ((i / 3) % 6)));
      check("scan_idx0", 32'(idx0), 32'((i / 4) % 8));
      check("scan_y2", 32'(y2), 32'(8'd1 << (i % 8)));
      check("scan_yv1", 32'(yv1), 32'd1);
    end
    check("scan_rdy0", 32'(rdy0), 32'd0);
    in_valid = 1'b0;

    mode = 1'b0;
    step();
    check("scan_exit_y1", 32'({yv1, y1}), 32'h00);

    // en=0 mid-scan at idx=3 aborts, re-entry restarts at 0
    mode = 1'b1;
    step();
    check("rescan_idx1", 32'(idx1), 32'd0);
    repeat (9) step();
    check("mid_idx1", 32'(idx1), 32'd3);
    en = 1'b0;
    step();
    check("en0_y1", 32'({yv1, y1}), 32'h00);
    check("en0_idx1", 32'(idx1), 32'd3);
    en = 1'b1;
    step();
    check("reenter_idx1", 32'(idx1), 32'd0);
    check("reenter_y1", 32'(y1), 32'h01);

    // Accept in the very cycle mode drops: takes priority over scan exit
    mode = 1'b0;
    accept(3'd4, 1'b0);
    in_valid = 1'b0;
    check("sw_accept_y0", 32'(y0), 32'h10);
    check("sw_accept_idx0", 32'(idx0), 32'd4);

    // Reset during hold
    rst_n = 1'b0;
    step();
    check("rst_hold_y0", 32'({yv0, y0}), 32'h000);
    check("rst_hold_idx0", 32'(idx0), 32'd0);
    check("rst_hold_rdy0", 32'(rdy0), 32'd0);
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
